// File: rtl/ysyx_23060332_wb_arb_pkg.sv
// Shared widths, pointer encodings and small helpers for the writeback arbiter
// and its load scoreboard.
package ysyx_23060332_wb_arb_pkg;

    localparam int RegAddrBus = 5;
    localparam int RegDataBus = 32;
    localparam int RegNum     = 1 << RegAddrBus;

    typedef enum logic {
        PTR_EXU = 1'b0,
        PTR_LSU = 1'b1
    } ptr_e;

    typedef struct packed {
        logic [RegAddrBus-1:0] addr;
        logic [RegDataBus-1:0] data;
    } wb_req_t;

    // x0 is hardwired: it is never written and never tracked as pending.
    function automatic logic addr_nonzero(input logic [RegAddrBus-1:0] a);
        return a != '0;
    endfunction

endpackage

// File: rtl/ysyx_23060332_scoreboard.sv
// Pending-load scoreboard: one busy bit per register, set by load issue,
// cleared by LSU writeback, with a read-port hazard check.
module ysyx_23060332_scoreboard
    import ysyx_23060332_wb_arb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en,
    input  logic [RegAddrBus-1:0] set_idx,
    input  logic                  clr_en,
    input  logic [RegAddrBus-1:0] clr_idx,
    input  logic [RegAddrBus-1:0] query_idx,
    output logic                  query_busy,
    input  logic [RegAddrBus-1:0] raddr1,
    input  logic [RegAddrBus-1:0] raddr2,
    output logic                  hazard
);

    logic [RegNum-1:0] busy_q;
    logic [RegNum-1:0] busy_d;

    genvar gi;
    generate
        for (gi = 0; gi < RegNum; gi++) begin : g_busy
            logic set_hit;
            logic clr_hit;

            assign set_hit = set_en && addr_nonzero(set_idx) && (set_idx == RegAddrBus'(gi));
            assign clr_hit = clr_en && (clr_idx == RegAddrBus'(gi));

            // A new load to the same register outranks the older load retiring.
            assign busy_d[gi] = set_hit ? 1'b1 : (clr_hit ? 1'b0 : busy_q[gi]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign query_busy = busy_q[query_idx];

    // No bypass: a load completing this cycle still reports a hazard until next cycle.
    assign hazard = (addr_nonzero(raddr1) && busy_q[raddr1]) ||
                    (addr_nonzero(raddr2) && busy_q[raddr2]);

endmodule

// File: rtl/ysyx_23060332_wb_arb.sv
// Writeback arbiter: round-robin merge of EXU and LSU results onto one registered
// regfile write port, with a load scoreboard guarding issue and operand reads.
module ysyx_23060332_wb_arb
    import ysyx_23060332_wb_arb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  exu_valid,
    output logic                  exu_ready,
    input  logic [RegAddrBus-1:0] exu_waddr,
    input  logic [RegDataBus-1:0] exu_wdata,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [RegAddrBus-1:0] lsu_waddr,
    input  logic [RegDataBus-1:0] lsu_wdata,
    input  logic                  iss_valid,
    output logic                  iss_ready,
    input  logic [RegAddrBus-1:0] iss_rd,
    input  logic [RegAddrBus-1:0] raddr1,
    input  logic [RegAddrBus-1:0] raddr2,
    output logic                  hazard,
    output logic                  reg_wen,
    output logic [RegAddrBus-1:0] waddr,
    output logic [RegDataBus-1:0] wdata
);

    ptr_e                  ptr_q;
    ptr_e                  ptr_d;
    logic                  exu_fire;
    logic                  lsu_fire;
    logic                  iss_fire;
    logic                  contended;
    logic                  rd_busy;
    wb_req_t               gnt_req;
    logic                  reg_wen_q;
    logic                  reg_wen_d;
    logic [RegAddrBus-1:0] waddr_q;
    logic [RegAddrBus-1:0] waddr_d;
    logic [RegDataBus-1:0] wdata_q;
    logic [RegDataBus-1:0] wdata_d;

    // Ready depends only on the other side's valid and the pointer, never on own valid.
    always_comb begin
        exu_ready = 1'b0;
        lsu_ready = 1'b0;
        if (!rst) begin
            exu_ready = !lsu_valid || (ptr_q == PTR_EXU);
            lsu_ready = !exu_valid || (ptr_q == PTR_LSU);
        end
    end

    assign exu_fire  = exu_valid && exu_ready;
    assign lsu_fire  = lsu_valid && lsu_ready;
    assign contended = exu_valid && lsu_valid;

    always_comb begin
        ptr_d = ptr_q;
        if (contended && !rst) begin
            ptr_d = exu_fire ? PTR_LSU : PTR_EXU;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= PTR_EXU;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    always_comb begin
        gnt_req.addr = exu_waddr;
        gnt_req.data = exu_wdata;
        if (lsu_fire) begin
            gnt_req.addr = lsu_waddr;
            gnt_req.data = lsu_wdata;
        end

        reg_wen_d = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        if (exu_fire || lsu_fire) begin
            reg_wen_d = addr_nonzero(gnt_req.addr);
            waddr_d   = gnt_req.addr;
            wdata_d   = gnt_req.data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_wen_q <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
        end else begin
            reg_wen_q <= reg_wen_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
        end
    end

    // Masking with rst kills a write that was registered just before reset rose.
    assign reg_wen = reg_wen_q && !rst;
    assign waddr   = rst ? '0 : waddr_q;
    assign wdata   = rst ? '0 : wdata_q;

    assign iss_ready = !rst && !rd_busy;
    assign iss_fire  = iss_valid && iss_ready;

    ysyx_23060332_scoreboard u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .set_en     (iss_fire),
        .set_idx    (iss_rd),
        .clr_en     (lsu_fire),
        .clr_idx    (lsu_waddr),
        .query_idx  (iss_rd),
        .query_busy (rd_busy),
        .raddr1     (raddr1),
        .raddr2     (raddr2),
        .hazard     (hazard)
    );

endmodule

// File: tb/tb_ysyx_23060332_wb_arb.sv
// Bench for the writeback arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_ysyx_23060332_wb_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        exu_valid;
    logic        exu_ready;
    logic [4:0]  exu_waddr;
    logic [31:0] exu_wdata;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_waddr;
    logic [31:0] lsu_wdata;
    logic        iss_valid;
    logic        iss_ready;
    logic [4:0]  iss_rd;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic        hazard;
    logic        reg_wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;

    always #5 clk = ~clk;

    ysyx_23060332_wb_arb dut (
        .clk       (clk),
        .rst       (rst),
        .exu_valid (exu_valid),
        .exu_ready (exu_ready),
        .exu_waddr (exu_waddr),
        .exu_wdata (exu_wdata),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_waddr (lsu_waddr),
        .lsu_wdata (lsu_wdata),
        .iss_valid (iss_valid),
        .iss_ready (iss_ready),
        .iss_rd    (iss_rd),
        .raddr1    (raddr1),
        .raddr2    (raddr2),
        .hazard    (hazard),
        .reg_wen   (reg_wen),
        .waddr     (waddr),
        .wdata     (wdata)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {31'b0, act}, {31'b0, exp});
    endtask

    // Behavioural model: set of pending registers, who goes first on a tie,
    // and the write the port must show next cycle.
    bit         busy_m [32];
    bit         prefer_lsu_m;
    bit         wen_m;
    logic [4:0] addr_m;
    logic [31:0] data_m;
    bit         known_m;
    bit         exu_fire_m;
    bit         lsu_fire_m;

    always @(negedge clk) begin
        bit eg;
        bit lg;
        bit ir;
        bit hz;
        if (rst) begin
            chk1("rst_reg_wen", reg_wen, 1'b0);
            chk("rst_waddr", {27'b0, waddr}, 32'd0);
            chk("rst_wdata", wdata, 32'd0);
            chk1("rst_exu_ready", exu_ready, 1'b0);
            chk1("rst_lsu_ready", lsu_ready, 1'b0);
            chk1("rst_iss_ready", iss_ready, 1'b0);
            for (int i = 0; i < 32; i++) busy_m[i] = 1'b0;
            prefer_lsu_m = 1'b0;
            wen_m        = 1'b0;
            addr_m       = 5'd0;
            data_m       = 32'd0;
            known_m      = 1'b1;
            exu_fire_m   = 1'b0;
            lsu_fire_m   = 1'b0;
        end else begin
            eg = exu_valid && (!lsu_valid || !prefer_lsu_m);
            lg = lsu_valid && (!exu_valid || prefer_lsu_m);
            if (exu_valid) chk1("exu_ready", exu_ready, eg);
            if (lsu_valid) chk1("lsu_ready", lsu_ready, lg);
            ir = !busy_m[iss_rd];
            chk1("iss_ready", iss_ready, ir);
            hz = (raddr1 != 0 && busy_m[raddr1]) || (raddr2 != 0 && busy_m[raddr2]);
            chk1("hazard", hazard, hz);
            chk1("reg_wen", reg_wen, wen_m);
            if (known_m) begin
                chk("waddr", {27'b0, waddr}, {27'b0, addr_m});
                chk("wdata", wdata, data_m);
            end

            if (exu_valid && lsu_valid) prefer_lsu_m = eg;
            if (lg) busy_m[lsu_waddr] = 1'b0;
            if (iss_valid && ir && iss_rd != 0) busy_m[iss_rd] = 1'b1;
            if (eg || lg) begin
                addr_m  = eg ? exu_waddr : lsu_waddr;
                data_m  = eg ? exu_wdata : lsu_wdata;
                wen_m   = (addr_m != 0);
                known_m = (addr_m != 0);
            end else begin
                wen_m = 1'b0;
            end
            exu_fire_m = eg;
            lsu_fire_m = lg;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    int exp_addr [4] = '{10, 11, 12, 13};
    bit was_rst;

    initial begin
        rst = 1'b1;
        exu_valid = 1'b1; exu_waddr = 5'd2; exu_wdata = 32'h22;
        lsu_valid = 1'b0; lsu_waddr = 5'd0; lsu_wdata = 32'h0;
        iss_valid = 1'b0; iss_rd = 5'd0; raddr1 = 5'd0; raddr2 = 5'd0;

        // Reset with a request pending: it must be discarded.
        repeat (3) begin
            mid();
            chk1("lit_rst_exu_ready", exu_ready, 1'b0);
            step();
        end

        // EXU only, first cycle out of reset.
        rst = 1'b0; exu_waddr = 5'd5; exu_wdata = 32'hDEADBEEF;
        mid();
        chk1("lit_exu_only_ready", exu_ready, 1'b1);
        chk1("lit_exu_only_nowen", reg_wen, 1'b0);
        step();
        exu_valid = 1'b0;
        mid();
        chk1("lit_exu_only_wen", reg_wen, 1'b1);
        chk("lit_exu_only_waddr", {27'b0, waddr}, 32'd5);
        chk("lit_exu_only_wdata", wdata, 32'hDEADBEEF);
        step();
        mid();
        chk1("lit_exu_only_wen_off", reg_wen, 1'b0);
        step();

        // Contention from pointer 0: EXU, LSU, EXU, LSU.
        exu_valid = 1'b1; exu_waddr = 5'd10; exu_wdata = 32'hA0;
        lsu_valid = 1'b1; lsu_waddr = 5'd11; lsu_wdata = 32'hB0;
        for (int k = 0; k < 4; k++) begin
            mid();
            chk1("lit_cont_exu_ready", exu_ready, (k % 2) == 0);
            chk1("lit_cont_lsu_ready", lsu_ready, (k % 2) == 1);
            if (k > 0) chk("lit_cont_waddr", {27'b0, waddr}, exp_addr[k-1]);
            step();
            if ((k % 2) == 0) begin
                exu_waddr = exu_waddr + 5'd2; exu_wdata = exu_wdata + 32'd1;
            end else begin
                lsu_waddr = lsu_waddr + 5'd2; lsu_wdata = lsu_wdata + 32'd1;
            end
        end
        exu_valid = 1'b0; lsu_valid = 1'b0;
        mid();
        chk("lit_cont_waddr_last", {27'b0, waddr}, exp_addr[3]);
        step();

        // Scoreboard: load to x7, hazard, WAW stall, clear by LSU.
        iss_valid = 1'b1; iss_rd = 5'd7; raddr1 = 5'd7;
        mid();
        chk1("lit_sb_iss_ready", iss_ready, 1'b1);
        chk1("lit_sb_hazard_pre", hazard, 1'b0);
        step();
        iss_valid = 1'b0;
        mid();
        chk1("lit_sb_hazard_set", hazard, 1'b1);
        step();
        lsu_valid = 1'b1; lsu_waddr = 5'd7; lsu_wdata = 32'h77; iss_valid = 1'b1;
        mid();
        chk1("lit_sb_hazard_nobypass", hazard, 1'b1);
        chk1("lit_sb_waw_stall", iss_ready, 1'b0);
        chk1("lit_sb_lsu_ready", lsu_ready, 1'b1);
        step();
        lsu_valid = 1'b0; iss_valid = 1'b0;
        mid();
        chk1("lit_sb_hazard_clr", hazard, 1'b0);
        step();

        // x0 write: handshake completes, no regfile write.
        exu_valid = 1'b1; exu_waddr = 5'd0; exu_wdata = 32'h1234;
        mid();
        chk1("lit_x0_ready", exu_ready, 1'b1);
        step();
        exu_valid = 1'b0;
        mid();
        chk1("lit_x0_nowen", reg_wen, 1'b0);
        step();

        // Same-cycle set and clear of x9: set wins.
        iss_valid = 1'b1; iss_rd = 5'd9; lsu_valid = 1'b1; lsu_waddr = 5'd9; raddr1 = 5'd9;
        mid();
        chk1("lit_sc_iss_ready", iss_ready, 1'b1);
        chk1("lit_sc_lsu_ready", lsu_ready, 1'b1);
        step();
        iss_valid = 1'b0; lsu_valid = 1'b0;
        mid();
        chk1("lit_sc_busy_hazard", hazard, 1'b1);
        chk1("lit_sc_busy_stall", iss_ready, 1'b0);
        step();
        lsu_valid = 1'b1;
        step();
        lsu_valid = 1'b0;

        // Reset right after a contended transfer with x3 pending.
        raddr1 = 5'd3; iss_valid = 1'b1; iss_rd = 5'd3;
        exu_valid = 1'b1; exu_waddr = 5'd4; exu_wdata = 32'h55;
        lsu_valid = 1'b1; lsu_waddr = 5'd6; lsu_wdata = 32'h66;
        mid();
        chk1("lit_rm_exu_ready", exu_ready, 1'b1);
        chk1("lit_rm_lsu_ready", lsu_ready, 1'b0);
        step();
        rst = 1'b1; exu_valid = 1'b0; iss_rd = 5'd5;
        mid();
        chk1("lit_rm_wen_suppressed", reg_wen, 1'b0);
        chk("lit_rm_waddr", {27'b0, waddr}, 32'd0);
        chk1("lit_rm_lsu_ready", lsu_ready, 1'b0);
        chk1("lit_rm_iss_ready", iss_ready, 1'b0);
        step();
        rst = 1'b0; exu_valid = 1'b1; iss_valid = 1'b0; iss_rd = 5'd3;
        mid();
        chk1("lit_rm_busy_cleared", hazard, 1'b0);
        chk1("lit_rm_iss_after", iss_ready, 1'b1);
        chk1("lit_rm_ptr_exu", exu_ready, 1'b1);
        chk1("lit_rm_ptr_lsu", lsu_ready, 1'b0);
        chk1("lit_rm_wen_after", reg_wen, 1'b0);
        step();
        exu_valid = 1'b0; lsu_valid = 1'b0;
        step();

        // Randomized traffic; requesters hold until accepted unless reset intervenes.
        for (int c = 0; c < 3000; c++) begin
            was_rst = rst;
            rst = ($urandom_range(0, 63) == 0);
            if (!exu_valid || exu_fire_m || was_rst) begin
                exu_valid = 1'($urandom_range(0, 1));
                exu_waddr = 5'($urandom_range(0, 7));
                exu_wdata = $urandom;
            end
            if (!lsu_valid || lsu_fire_m || was_rst) begin
                lsu_valid = 1'($urandom_range(0, 1));
                lsu_waddr = 5'($urandom_range(0, 7));
                lsu_wdata = $urandom;
            end
            iss_valid = 1'($urandom_range(0, 1));
            iss_rd    = 5'($urandom_range(0, 7));
            raddr1    = 5'($urandom_range(0, 7));
            raddr2    = 5'($urandom_range(0, 31));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
